// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register index and pipeline control FSM states
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    // RUN:    no completed data access is being held
    // SERVED: the data access finished but the pipeline is still frozen on ihit
    // HALT:   terminal until reset
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SERVED = 2'd1,
        HALT   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// rtl/pipeline_control_unit_sat_counter.sv - saturating up-counter
//   CLK, nRST : clock, async active-low reset
//   en_i      : count this cycle
//   count_o   : current count, sticks at all-ones
module saturating_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count_q <= '0;
        else if (en_i && (count_q != {W{1'b1}}))
            count_q <= count_q + {{(W-1){1'b0}}, 1'b1};
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - stall/flush controller for the 5-stage pipeline
//   CLK, nRST            : clock, async active-low reset
//   ihit, dhit           : instruction / data access complete
//   mem_dREN, mem_dWEN   : memory request held in EX/MEM
//   ex_dREN, ex_wsel     : load in EX and its destination
//   id_rs, id_rt         : sources of the instruction in ID
//   ex_redirect          : taken branch/jump resolved in EX
//   wb_halt              : halt reached WB
//   pc_en, *_en, *_flush : pipeline register controls
//   exmem_clearMemReq    : drop EX/MEM request and capture memData
//   halted               : core halted
//   stall_cycles         : frozen-pipeline cycle count
module pipeline_control_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  regbits_t         ex_wsel,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             exmem_clearMemReq,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    ctrl_state_t state_q, state_d;

    logic mem_req, mem_ok, advance, load_use;

    assign mem_req  = mem_dREN | mem_dWEN;
    // A held SERVED access satisfies the memory stage even though the
    // EX/MEM request bits are still visible to us.
    assign mem_ok   = !mem_req | dhit | (state_q == SERVED);
    assign advance  = ihit & mem_ok & (state_q != HALT);
    assign load_use = ex_dREN & (ex_wsel != 5'd0) &
                      ((ex_wsel == id_rs) | (ex_wsel == id_rt));

    always_comb begin
        pc_en             = 1'b0;
        ifid_en           = 1'b0;
        idex_en           = 1'b0;
        exmem_en          = 1'b0;
        memwb_en          = 1'b0;
        ifid_flush        = 1'b0;
        idex_flush        = 1'b0;
        exmem_flush       = 1'b0;
        memwb_flush       = 1'b0;
        exmem_clearMemReq = 1'b0;
        halted            = (state_q == HALT);
        state_d           = state_q;

        if (state_q != HALT) begin
            if (advance) begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                // Redirect squashes the ID instruction, so a load-use
                // bubble against it would be pointless.
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end else begin
                // Frozen: keep WB from retiring the same result again.
                memwb_flush = 1'b1;
            end

            if (state_q == RUN && dhit && mem_req && !advance) begin
                exmem_clearMemReq = 1'b1;
                state_d           = SERVED;
            end else if (state_q == SERVED && advance) begin
                state_d = RUN;
            end

            if (wb_halt)
                state_d = HALT;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    saturating_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK     (CLK),
        .nRST    (nRST),
        .en_i    (!advance && (state_q != HALT)),
        .count_o (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - scoreboard bench for pipeline_control_unit
module tb_pipeline_control_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_redirect, wb_halt;
    logic [4:0]  ex_wsel, id_rs, id_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        exmem_clearMemReq, halted;
    logic [31:0] stall_cycles;

    pipeline_control_unit #(.CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
        .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
        .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .exmem_clearMemReq(exmem_clearMemReq), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit       rst_n, ih, dh, mr, mw, exr, redir, halt;
        bit [4:0] wsel, rs, rt;
    } stim_t;

    typedef struct {
        bit [10:0]   ctl;
        bit [31:0]   cnt;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;

    // Reference model: just "holding a served access", "halted" and a count.
    bit          m_served = 0;
    bit          m_halted = 0;
    longint      m_cnt = 0;

    task automatic step(input stim_t s);
        bit mem_req, adv, lu, clr;
        bit pc, e_if, e_id, e_ex, e_wb, f_if, f_id, f_wb;
        exp_t e;
        @(posedge CLK);
        #1;
        nRST = s.rst_n; ihit = s.ih; dhit = s.dh; mem_dREN = s.mr; mem_dWEN = s.mw;
        ex_dREN = s.exr; ex_redirect = s.redir; wb_halt = s.halt;
        ex_wsel = s.wsel; id_rs = s.rs; id_rt = s.rt;
        if (!s.rst_n) begin
            m_served = 0; m_halted = 0; m_cnt = 0;
        end
        mem_req = s.mr || s.mw;
        adv = !m_halted && s.ih && (!mem_req || s.dh || m_served);
        lu  = s.exr && s.wsel != 0 && (s.wsel == s.rs || s.wsel == s.rt);
        clr = !m_halted && !m_served && s.dh && mem_req && !adv;
        {pc, e_if, e_id, e_ex, e_wb, f_if, f_id, f_wb} = '0;
        if (adv) begin
            {pc, e_if, e_id, e_ex, e_wb} = 5'b11111;
            if (s.redir) begin f_if = 1; f_id = 1; end
            else if (lu) begin pc = 0; e_if = 0; f_id = 1; end
        end else if (!m_halted) begin
            f_wb = 1;
        end
        e.ctl = {pc, e_if, e_id, e_ex, e_wb, f_if, f_id, 1'b0, f_wb, clr, m_halted};
        e.cnt = m_cnt[31:0];
        e.id  = n_step++;
        exp_q.push_back(e);
        // Advance the model to the state seen after the coming clock edge.
        if (s.rst_n && !m_halted) begin
            if (!adv && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (clr) m_served = 1;
            else if (adv) m_served = 0;
            if (s.halt) begin m_halted = 1; m_served = 0; end
        end
    endtask

    always @(negedge CLK) begin
        exp_t     e;
        bit [10:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                   exmem_flush, memwb_flush, exmem_clearMemReq, halted};
            n_cmp++;
            if (act !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl step %0d: got %b want %b", e.id, act, e.ctl);
            end
            n_cmp++;
            if (stall_cycles !== e.cnt) begin
                n_bad++;
                $display("FAIL stall_cycles step %0d: got %0d want %0d", e.id, stall_cycles, e.cnt);
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n:1, ih:1, dh:0, mr:0, mw:0, exr:0, redir:0, halt:0, wsel:0, rs:0, rt:0};
        return s;
    endfunction

    initial begin
        stim_t s;
        {ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_redirect, wb_halt} = '0;
        {ex_wsel, id_rs, id_rt} = '0;

        // Reset, then a free-running cycle.
        s = idle(); s.rst_n = 0; step(s); step(s);
        s = idle(); step(s); step(s);

        // Three dcache wait cycles then the hit.
        s = idle(); s.mr = 1;
        repeat (3) step(s);
        s.dh = 1; step(s);
        s = idle(); step(s);

        // Data done while fetch is still waiting: held as served.
        s = idle(); s.ih = 0; s.mr = 1; s.dh = 1; step(s);
        s.dh = 0; step(s); step(s);
        s.ih = 1; step(s);
        s = idle(); step(s);

        // Load-use on rt, then with r0 destination.
        s = idle(); s.exr = 1; s.wsel = 8; s.rt = 8; s.rs = 3; step(s);
        s.wsel = 0; s.rt = 0; step(s);
        // Redirect over load-use.
        s = idle(); s.exr = 1; s.wsel = 8; s.rt = 8; s.redir = 1; step(s);

        // Halt with a stall in the same cycle, then frozen, then reset.
        s = idle(); s.halt = 1; s.ih = 0; step(s);
        s = idle(); s.mr = 1; repeat (3) step(s);
        s = idle(); s.rst_n = 0; step(s);
        s = idle(); step(s);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = !($urandom_range(0, 199) == 0) && !(m_halted && $urandom_range(0, 7) == 0);
            s.ih    = $urandom_range(0, 3) != 0;
            s.dh    = $urandom_range(0, 2) == 0;
            s.mr    = $urandom_range(0, 3) == 0;
            s.mw    = $urandom_range(0, 5) == 0;
            s.exr   = $urandom_range(0, 2) == 0;
            s.redir = $urandom_range(0, 5) == 0;
            s.halt  = $urandom_range(0, 99) == 0;
            s.wsel  = 5'($urandom_range(0, 3));
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            step(s);
        end

        repeat (3) @(posedge CLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
Name: pipeline_control_unit

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the enable, flush and clearMemReq inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC enable.
- Arbitrates instruction-cache wait (ihit), data-cache wait (dhit), load-use hazards, taken branches/jumps and halt.
- Holds a small FSM that remembers a completed data access while the pipeline is still frozen on ihit.

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dREN  in  1  dREN_out of EX/MEM.
- mem_dWEN  in  1  dWEN_out of EX/MEM.
- ex_dREN  in  1  dREN_out of ID/EX (load in EX).
- ex_wsel  in  5  destination register of the instruction in EX.
- id_rs  in  5  rs of the instruction in ID.
- id_rt  in  5  rt of the instruction in ID.
- ex_redirect  in  1  taken branch, jump, jr or jal resolved in EX.
- wb_halt  in  1  halt_out of MEM/WB.
- pc_en  out  1  PC may update.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register flushes.
- exmem_clearMemReq  out  1  drop the EX/MEM request and capture memData.
- halted  out  1  core halted.
- stall_cycles  out  CNT_W  count of cycles with advance=0 while not halted.

Behaviour:
- Reset: FSM=RUN and stall_cycles=0. All outputs are combinational and settle to their RUN values.
- States:
  - RUN: no served access pending.
  - SERVED: the data access finished but the pipeline has not advanced yet.
  - HALT: terminal state.
- Definitions:
  - mem_req = mem_dREN | mem_dWEN.
  - mem_ok = !mem_req | dhit | (state==SERVED).
  - advance = ihit & mem_ok & (state!=HALT).
- RUN transitions:
  - dhit & mem_req & !advance → SERVED. Assert exmem_clearMemReq=1 in that cycle; the EX/MEM register clears dREN/dWEN and latches memData.
  - wb_halt → HALT.
- SERVED transitions:
  - advance → RUN.
  - exmem_clearMemReq=0 while in SERVED.
  - Any dhit in SERVED is ignored.
- HALT: all enables 0, all flushes 0, pc_en=0, halted=1. Leaves only on reset.
- Default when advance=1: pc_en and all four enables = 1, all flushes = 0.
- Default when advance=0: pc_en and all enables = 0. memwb_flush=1 so the WB stage never writes the same result twice. Other flushes = 0.
- Load-use hazard: lu = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt).
  - With advance & lu: pc_en=0, ifid_en=0, idex_flush=1. EX/MEM and MEM/WB enabled. Exactly one bubble is inserted.
- Redirect with advance & ex_redirect:
  - pc_en=1, ifid_flush=1, idex_flush=1.
  - ex_redirect overrides lu, since the ID instruction is squashed anyway.
- Simultaneous wb_halt and any other condition: HALT wins in the next cycle. The current cycle still follows the rules above.
- exmem_flush: tied 0 in this revision; reserved for exceptions.
- stall_cycles:
  - Increments by 1 each cycle with !advance & state!=HALT.
  - Saturates at all-ones.
  - Frozen in HALT.
- Asynchronous reset mid-stall returns to RUN. Any partially served access is discarded.

Decomposition:
- Shared package cpu_types_pkg:
  - regbits_t (5-bit).
  - New typedef ctrl_state_t enum {RUN, SERVED, HALT}.
- No sub-module required. The counter may be a small saturating_counter sub-module, parameterised on CNT_W.

Test Plan:
- Reset then ihit=1, no mem → all enables 1, flushes 0, stall_cycles=0.
- mem_dREN=1, ihit=1, dhit=0 for 3 cycles, then dhit=1:
  - Enables 0 and memwb_flush=1 during the 3 stall cycles.
  - advance in the 4th cycle.
  - stall_cycles=3.
- mem_dREN=1, dhit=1 while ihit=0:
  - exmem_clearMemReq=1 for one cycle; state SERVED.
  - After 2 further cycles ihit=1 → advance=1, even with mem_dREN still asserted and dhit=0.
- ex_dREN=1, ex_wsel=8, id_rt=8, ihit=1:
  - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
  - The same with ex_wsel=0 produces no stall.
- ex_redirect=1 together with the load-use condition above → pc_en=1, ifid_flush=1, idex_flush=1.
- wb_halt=1 → next cycle halted=1, all enables 0, stall_cycles frozen; nRST low → RUN.
